uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_rx_fifo.sv | 51 +++++
 rtl/uart_rx.sv | 227 ++++++++++++++++++++++
 tb/tb_uart_rx.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: receive FSM states and oversampling default.
package uart_pkg;

   localparam int OVERSAMPLE_DEF = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO: pointers carry an extra wrap bit so full and empty are distinct,
// head byte is read straight out of storage.
module uart_rx_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] wdata,
   output logic [7:0] data,
   output logic       full,
   output logic       empty
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]  mem_r [DEPTH];
   logic [AW:0] wr_ptr_r;
   logic [AW:0] rd_ptr_r;
   logic        pop_ok_s;
   logic        push_ok_s;

   assign empty     = (wr_ptr_r == rd_ptr_r);
   assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                      (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   // A pop in the same cycle frees the slot a push on a full FIFO needs.
   assign pop_ok_s  = pop && !empty;
   assign push_ok_s = push && (!full || pop_ok_s);
   assign data      = mem_r[rd_ptr_r[AW-1:0]];

   // Storage and pointer update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= 8'h00;
         end
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (push_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
            wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver (8N1): synchronizer, tick generator, frame FSM,
// sticky error flags, and a small receive FIFO.
module uart_rx
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
   input  logic        clk,
   input  logic        power_on_reset_n,
   input  logic        rx,
   input  logic [15:0] divisor,
   input  logic        rd,
   output logic [7:0]  rdata,
   output logic        rx_valid,
   output logic        framing_err,
   output logic        overrun,
   input  logic        clr_err
);

   localparam int SW = $clog2(OVERSAMPLE);
   localparam logic [SW-1:0] HALF_M1 = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] LAST    = SW'(OVERSAMPLE - 1);

   rx_state_e   state_r;
   rx_state_e   state_nxt_s;
   logic        sync1_r;
   logic        sync2_r;
   logic        rx_s;
   logic [1:0]  settle_r;
   logic        armed_r;
   logic [15:0] div_r;
   logic [15:0] tick_cnt_r;
   logic        tick_s;
   logic [SW-1:0] samp_cnt_r;
   logic [2:0]  bit_idx_r;
   logic [7:0]  shift_r;
   logic        hold_r;
   logic        ferr_r;
   logic        ovr_r;
   logic        mid_s;
   logic        bit_s;
   logic        cnt_clr_s;
   logic        samp_clr_s;
   logic        shift_en_s;
   logic        push_s;
   logic        ferr_set_s;
   logic        hold_set_s;
   logic        hold_clr_s;
   logic        ovr_set_s;
   logic        full_s;
   logic        empty_s;

   assign rx_s   = sync2_r;
   assign tick_s = (tick_cnt_r == div_r);
   assign mid_s  = tick_s && (samp_cnt_r == HALF_M1);
   assign bit_s  = tick_s && (samp_cnt_r == LAST);

   // Two-flop synchronizer; resets to the idle line level.
   always_ff @(posedge clk or negedge power_on_reset_n) begin
      if (!power_on_reset_n) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
      end else begin
         sync1_r <= rx;
         sync2_r <= sync1_r;
      end
   end

   // After reset, a start bit is only accepted once the real line has been seen high,
   // so a frame cut short by reset cannot be picked up mid-stream.
   always_ff @(posedge clk or negedge power_on_reset_n) begin
      if (!power_on_reset_n) begin
         settle_r <= 2'd0;
         armed_r  <= 1'b0;
      end else begin
         if (settle_r != 2'd3) begin
            settle_r <= settle_r + 2'd1;
         end
         if (!armed_r && (settle_r == 2'd3) && rx_s) begin
            armed_r <= 1'b1;
         end
      end
   end

   // Frame FSM state register.
   always_ff @(posedge clk or negedge power_on_reset_n) begin
      if (!power_on_reset_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state and datapath control.
   always_comb begin
      state_nxt_s = state_r;
      cnt_clr_s   = 1'b0;
      samp_clr_s  = 1'b0;
      shift_en_s  = 1'b0;
      push_s      = 1'b0;
      ferr_set_s  = 1'b0;
      hold_set_s  = 1'b0;
      hold_clr_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (armed_r && !rx_s) begin
               cnt_clr_s   = 1'b1;
               state_nxt_s = START;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         START: begin
            if (mid_s) begin
               samp_clr_s  = 1'b1;
               state_nxt_s = rx_s ? IDLE : DATA;
            end else begin
               state_nxt_s = START;
            end
         end
         DATA: begin
            if (bit_s) begin
               samp_clr_s  = 1'b1;
               shift_en_s  = 1'b1;
               state_nxt_s = (bit_idx_r == 3'd7) ? STOP : DATA;
            end else begin
               state_nxt_s = DATA;
            end
         end
         STOP: begin
            if (hold_r) begin
               // Bad stop bit: wait for the line to return high before re-arming.
               if (rx_s) begin
                  hold_clr_s  = 1'b1;
                  state_nxt_s = IDLE;
               end else begin
                  state_nxt_s = STOP;
               end
            end else if (bit_s) begin
               samp_clr_s = 1'b1;
               if (rx_s) begin
                  push_s      = 1'b1;
                  state_nxt_s = IDLE;
               end else begin
                  ferr_set_s  = 1'b1;
                  hold_set_s  = 1'b1;
                  state_nxt_s = STOP;
               end
            end else begin
               state_nxt_s = STOP;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Tick generator, sample counter, bit index and shift register.
   always_ff @(posedge clk or negedge power_on_reset_n) begin
      if (!power_on_reset_n) begin
         div_r      <= 16'd0;
         tick_cnt_r <= 16'd0;
         samp_cnt_r <= '0;
         bit_idx_r  <= 3'd0;
         shift_r    <= 8'h00;
         hold_r     <= 1'b0;
      end else begin
         if (cnt_clr_s || tick_s) begin
            tick_cnt_r <= 16'd0;
            div_r      <= divisor;
         end else begin
            tick_cnt_r <= tick_cnt_r + 16'd1;
         end
         if (cnt_clr_s || samp_clr_s) begin
            samp_cnt_r <= '0;
         end else if (tick_s) begin
            samp_cnt_r <= samp_cnt_r + SW'(1);
         end
         if (cnt_clr_s) begin
            bit_idx_r <= 3'd0;
         end else if (shift_en_s) begin
            bit_idx_r <= bit_idx_r + 3'd1;
         end
         if (shift_en_s) begin
            shift_r <= {rx_s, shift_r[7:1]};
         end
         if (hold_set_s) begin
            hold_r <= 1'b1;
         end else if (hold_clr_s) begin
            hold_r <= 1'b0;
         end
      end
   end

   assign ovr_set_s = push_s && full_s && !rd;

   // Sticky error flags; a new error in the clearing cycle keeps the flag set.
   always_ff @(posedge clk or negedge power_on_reset_n) begin
      if (!power_on_reset_n) begin
         ferr_r <= 1'b0;
         ovr_r  <= 1'b0;
      end else begin
         ferr_r <= ferr_set_s | (ferr_r & ~clr_err);
         ovr_r  <= ovr_set_s  | (ovr_r  & ~clr_err);
      end
   end

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (power_on_reset_n),
      .push  (push_s),
      .pop   (rd),
      .wdata (shift_r),
      .data  (rdata),
      .full  (full_s),
      .empty (empty_s)
   );

   assign rx_valid    = !empty_s;
   assign framing_err = ferr_r;
   assign overrun     = ovr_r;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a queue/flag model of the receiver is advanced from
// the known frame timing and compared against the DUT every cycle.
module tb_uart_rx;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        power_on_reset_n;
   logic        rx;
   logic [15:0] divisor;
   logic        rd;
   logic [7:0]  rdata;
   logic        rx_valid;
   logic        framing_err;
   logic        overrun;
   logic        clr_err;

   always #5 clk = ~clk;

   uart_rx #(.FIFO_DEPTH(DEPTH), .OVERSAMPLE(16)) dut (
      .clk              (clk),
      .power_on_reset_n (power_on_reset_n),
      .rx               (rx),
      .divisor          (divisor),
      .rd               (rd),
      .rdata            (rdata),
      .rx_valid         (rx_valid),
      .framing_err      (framing_err),
      .overrun          (overrun),
      .clr_err          (clr_err)
   );

   // Reference model: received bytes, sticky flags, and whether storage is still at reset.
   logic [7:0] q[$];
   bit         m_ferr;
   bit         m_ovr;
   bit         m_fresh;
   bit         chk_en = 1'b0;
   int         tests = 0;
   int         fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison just after the active edge.
   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         chk("rx_valid", {31'd0, rx_valid}, {31'd0, (q.size() != 0)});
         chk("framing_err", {31'd0, framing_err}, {31'd0, m_ferr});
         chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
         if (q.size() != 0) begin
            chk("rdata_head", {24'd0, rdata}, {24'd0, q[0]});
         end else if (m_fresh) begin
            chk("rdata_reset", {24'd0, rdata}, 32'd0);
         end
      end
   end

   // Drive one cycle of inputs and advance the model to the state after the next edge.
   task automatic step(input logic rx_v, input logic rd_v, input logic clr_v, input logic rst_v,
                       input bit push_ev, input bit ferr_ev, input logic [7:0] pdata);
      @(negedge clk);
      rx = rx_v;
      rd = rd_v;
      clr_err = clr_v;
      power_on_reset_n = rst_v;
      if (!rst_v) begin
         q.delete();
         m_ferr = 1'b0;
         m_ovr = 1'b0;
         m_fresh = 1'b1;
      end else begin
         if (rd_v && q.size() > 0) void'(q.pop_front());
         if (clr_v) begin
            m_ferr = 1'b0;
            m_ovr = 1'b0;
         end
         if (ferr_ev) m_ferr = 1'b1;
         if (push_ev) begin
            if (q.size() < DEPTH) begin
               q.push_back(pdata);
               m_fresh = 1'b0;
            end else begin
               m_ovr = 1'b1;
            end
         end
      end
   endtask

   task automatic idle(input int n, input bit rand_rd);
      for (int i = 0; i < n; i++) begin
         step(1'b1, rand_rd && ($urandom_range(0, 2) == 0), 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      end
   endtask

   // One 8N1 frame. The stop-bit decision lands 2 sync cycles + half a start bit + 9 bits
   // after the start edge is driven, i.e. at cycle 2 + 152*(div+1).
   task automatic send_frame(input logic [7:0] d, input logic stop, input int div,
                             input int rd_cyc, input int clr_cyc, input int rst_cyc);
      int bl;
      int pc;
      bit aborted;
      bl = 16 * (div + 1);
      pc = 2 + 152 * (div + 1);
      aborted = (rst_cyc >= 0) && (rst_cyc < pc);
      for (int c = 0; c < 10 * bl; c++) begin
         int   slot;
         logic b;
         slot = c / bl;
         if (slot == 0) b = 1'b0;
         else if (slot == 9) b = stop;
         else b = d[slot - 1];
         step(b, c == rd_cyc, c == clr_cyc, c != rst_cyc,
              (c == pc) && stop && !aborted, (c == pc) && !stop && !aborted, d);
      end
   endtask

   task automatic read_expect(input logic [7:0] exp, input string name);
      chk(name, {24'd0, rdata}, {24'd0, exp});
      chk("read_valid", {31'd0, rx_valid}, 32'd1);
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
   endtask

   initial begin
      power_on_reset_n = 1'b0;
      rx = 1'b1;
      rd = 1'b0;
      clr_err = 1'b0;
      divisor = 16'd0;
      m_ferr = 1'b0;
      m_ovr = 1'b0;
      m_fresh = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
      chk("reset_rdata", {24'd0, rdata}, 32'd0);
      chk("reset_ferr", {31'd0, framing_err}, 32'd0);
      chk("reset_ovr", {31'd0, overrun}, 32'd0);
      chk_en = 1'b1;
      idle(10, 1'b0);

      // Basic frame then pop.
      send_frame(8'hA5, 1'b1, 0, -1, -1, -1);
      idle(3, 1'b0);
      chk("a5_valid", {31'd0, rx_valid}, 32'd1);
      read_expect(8'hA5, "a5_data");
      chk("a5_empty", {31'd0, rx_valid}, 32'd0);

      // Start-bit glitch is rejected.
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      idle(30, 1'b0);
      chk("glitch_valid", {31'd0, rx_valid}, 32'd0);

      // Bad stop bit, recovery, clear.
      send_frame(8'h3C, 1'b0, 0, -1, -1, -1);
      idle(8, 1'b0);
      chk("ferr_set", {31'd0, framing_err}, 32'd1);
      chk("ferr_valid", {31'd0, rx_valid}, 32'd0);
      send_frame(8'h11, 1'b1, 0, -1, -1, -1);
      idle(3, 1'b0);
      chk("after_ferr_data", {24'd0, rdata}, 32'h11);
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      idle(2, 1'b0);
      chk("ferr_cleared", {31'd0, framing_err}, 32'd0);
      read_expect(8'h11, "read_11");

      // Overrun: fifth byte dropped.
      for (int i = 1; i <= 5; i++) begin
         send_frame(8'(i), 1'b1, 0, -1, -1, -1);
         idle(2, 1'b0);
      end
      chk("ovr_set", {31'd0, overrun}, 32'd1);
      read_expect(8'h01, "ovr_r1");
      read_expect(8'h02, "ovr_r2");
      read_expect(8'h03, "ovr_r3");
      read_expect(8'h04, "ovr_r4");
      chk("ovr_drained", {31'd0, rx_valid}, 32'd0);
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      idle(2, 1'b0);

      // Full FIFO with pop on the push cycle: no overrun.
      for (int i = 1; i <= 4; i++) begin
         send_frame(8'(i), 1'b1, 0, -1, -1, -1);
         idle(2, 1'b0);
      end
      send_frame(8'h55, 1'b1, 0, 154, -1, -1);
      idle(2, 1'b0);
      chk("full_pop_ovr", {31'd0, overrun}, 32'd0);
      read_expect(8'h02, "fp_r1");
      read_expect(8'h03, "fp_r2");
      read_expect(8'h04, "fp_r3");
      read_expect(8'h55, "fp_r4");

      // Reset pulse during data bit 3 of a frame.
      send_frame(8'h99, 1'b1, 0, -1, -1, -1);
      idle(2, 1'b0);
      send_frame(8'hF0, 1'b1, 0, -1, -1, 72);
      idle(30, 1'b0);
      chk("rst_mid_valid", {31'd0, rx_valid}, 32'd0);
      chk("rst_mid_rdata", {24'd0, rdata}, 32'd0);
      send_frame(8'h7E, 1'b1, 0, -1, -1, -1);
      idle(3, 1'b0);
      read_expect(8'h7E, "after_rst_7e");

      // Slower tick: divisor 1, 32 clk per bit.
      divisor = 16'd1;
      idle(5, 1'b0);
      send_frame(8'hC3, 1'b1, 1, -1, -1, -1);
      idle(5, 1'b0);
      read_expect(8'hC3, "div1_c3");
      divisor = 16'd0;
      idle(5, 1'b0);

      // Randomized frames, stop bits, pops and clears.
      for (int n = 0; n < 40; n++) begin
         logic [7:0] d;
         logic       stop;
         int         rc;
         int         cc;
         d = 8'($urandom);
         stop = ($urandom_range(0, 5) != 0);
         rc = $urandom_range(0, 239);
         cc = $urandom_range(0, 319);
         if (rc >= 160) rc = -1;
         if ($urandom_range(0, 3) == 0) cc = 154;
         else if (cc >= 160) cc = -1;
         send_frame(d, stop, 0, rc, cc, -1);
         idle(stop ? $urandom_range(0, 8) : $urandom_range(4, 10), 1'b1);
      end
      idle(20, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
